// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU requests in a 4-entry FIFO, issues them one at
// a time to an external 4-bit combinational ALU, and holds each captured
// result until the downstream side accepts it.
module alu_issue_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_y,
  input  logic       alu_carry,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_y,
  output logic       out_carry,
  output logic       out_illegal,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t      state_r;
  logic [10:0] fifo_mem_r [0:3];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  count_r;

  logic        push_s;
  logic        pop_s;
  logic        fifo_empty_s;
  logic [10:0] head_s;

  // in_ready depends on the registered count only, so a same-cycle pop
  // never opens a slot for a push into a full FIFO.
  assign in_ready = (count_r != 3'd4);

  // Push/pop decisions; pop is taken when the FSM is ready to load the ALU.
  always_comb begin
    push_s       = in_valid && (count_r != 3'd4);
    fifo_empty_s = (count_r == 3'd0);
    head_s       = fifo_mem_r[rd_ptr_r];
    pop_s        = 1'b0;
    case (state_r)
      IDLE:    pop_s = !fifo_empty_s;
      RESULT:  pop_s = out_ready && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage, pointers (wrap modulo 4) and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 11'd0;
      end
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {in_a, in_b, in_op};
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM: loads the ALU operands, captures the ALU result one edge
  // later, then holds it until downstream accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alu_a       <= 4'd0;
      alu_b       <= 4'd0;
      alu_op      <= 3'd0;
      out_valid   <= 1'b0;
      out_y       <= 4'd0;
      out_carry   <= 1'b0;
      out_illegal <= 1'b0;
      op_count    <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            alu_a   <= head_s[10:7];
            alu_b   <= head_s[6:3];
            alu_op  <= head_s[2:0];
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          out_y       <= alu_y;
          out_carry   <= alu_carry;
          out_illegal <= (alu_op == 3'b111);
          out_valid   <= 1'b1;
          state_r     <= RESULT;
        end
        RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            if (pop_s) begin
              alu_a   <= head_s[10:7];
              alu_b   <= head_s[6:3];
              alu_op  <= head_s[2:0];
              state_r <= ISSUE;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= RESULT;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: provides a behavioural 4-bit ALU, drives
// directed and random requests, and checks the DUT every cycle against a
// queue-based model of the request/result flow.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_y;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic       out_carry;
  logic       out_illegal;
  logic [7:0] op_count;

  int checks;
  int failures;

  // Model state: queued requests, the request held by the ALU path, its
  // phase (0 none, 1 being computed, 2 presented) and the accepted count.
  logic [10:0] mq[$];
  logic [10:0] m_cur;
  int          m_phase;
  logic [7:0]  m_count;
  int          total_acc;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_carry  (out_carry),
    .out_illegal(out_illegal),
    .op_count   (op_count)
  );

  // Behavioural ALU: returns {carry, y}. Sub carry means no borrow; shifts
  // move by one and carry out the bit shifted off; 111 yields zero.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    int r;
    case (op)
      3'd0:    r = int'(a) + int'(b);
      3'd1:    r = ((int'(a) - int'(b)) & 15) + ((a >= b) ? 16 : 0);
      3'd2:    r = int'(a & b);
      3'd3:    r = int'(a | b);
      3'd4:    r = int'(a ^ b);
      3'd5:    r = ((int'(a) * 2) & 15) + (a[3] ? 16 : 0);
      3'd6:    r = int'(a) / 2 + (a[0] ? 16 : 0);
      default: r = 0;
    endcase
    return r[4:0];
  endfunction

  assign {alu_carry, alu_y} = alu_f(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model (called once per cycle).
  task automatic check_outputs();
    logic [4:0] r;
    chk("in_ready", int'(in_ready), (mq.size() != 4) ? 1 : 0);
    chk("out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
    chk("op_count", int'(op_count), int'(m_count));
    if (m_phase == 2) begin
      r = alu_f(m_cur[10:7], m_cur[6:3], m_cur[2:0]);
      chk("out_y", int'(out_y), int'(r[3:0]));
      chk("out_carry", int'(out_carry), int'(r[4]));
      chk("out_illegal", int'(out_illegal), (m_cur[2:0] == 3'd7) ? 1 : 0);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur     = 11'd0;
    m_phase   = 0;
    m_count   = 8'd0;
    total_acc = 0;
  endtask

  // One clock cycle: check at the falling edge, drive, advance the model.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] op, input logic ordy);
    logic do_push;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    do_push   = v && (mq.size() != 4);
    if (m_phase == 0) begin
      if (mq.size() > 0) begin
        m_cur   = mq.pop_front();
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      if (ordy) begin
        m_count = m_count + 8'd1;
        total_acc++;
        if (mq.size() > 0) begin
          m_cur   = mq.pop_front();
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end
    if (do_push) mq.push_back({a, b, op});
    @(posedge clk);
  endtask

  task automatic idle_step(input logic ordy);
    step(1'b0, 4'd0, 4'd0, 3'd0, ordy);
  endtask

  task automatic rand_step(input int pv, input int pr);
    step(($urandom_range(99) < pv) ? 1'b1 : 1'b0, 4'($urandom_range(15)),
         4'($urandom_range(15)), 3'($urandom_range(7)),
         ($urandom_range(99) < pr) ? 1'b1 : 1'b0);
  endtask

  // Single request into an idle, empty block with literal expectations.
  task automatic single(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input int ey, input int ec,
                        input int ei, input int ecount);
    step(1'b1, a, b, op, 1'b1);
    idle_step(1'b1);
    chk({name, "_valid_early"}, int'(out_valid), 0);
    idle_step(1'b1);
    #2;
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_y"}, int'(out_y), ey);
    chk({name, "_carry"}, int'(out_carry), ec);
    chk({name, "_illegal"}, int'(out_illegal), ei);
    idle_step(1'b1);
    #2;
    chk({name, "_count"}, int'(op_count), ecount);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() != 0 || m_phase != 0); i++) begin
      idle_step(1'b1);
    end
    chk("drain_done", (mq.size() == 0 && m_phase == 0) ? 1 : 0, 1);
  endtask

  initial begin
    int guard;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'd1;
    in_b      = 4'd2;
    in_op     = 3'd0;
    out_ready = 1'b1;
    model_reset();

    // Reset state, with in_valid high and ignored.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_alu", int'({alu_a, alu_b, alu_op}), 0);
    chk("rst_out", int'({out_y, out_carry, out_illegal}), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);

    // Directed single operations.
    single("add", 4'd9, 4'd8, 3'd0, 1, 1, 0, 1);
    single("ill", 4'd3, 4'd3, 3'd7, 0, 0, 1, 2);
    single("and", 4'd6, 4'd3, 3'd2, 2, 0, 0, 3);
    single("sub", 4'd2, 4'd5, 3'd1, 13, 0, 0, 4);
    single("shl", 4'd9, 4'd0, 3'd5, 2, 1, 0, 5);
    single("shr", 4'd9, 4'd0, 3'd6, 4, 1, 0, 6);

    // Backpressure: five back-to-back pushes fill the FIFO plus one issued.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i + 1), 4'(i + 2), 3'(i), 1'b0);
    end
    #2;
    chk("bp_in_ready", int'(in_ready), 0);
    step(1'b1, 4'd15, 4'd15, 3'd0, 1'b0);
    idle_step(1'b0);
    drain();
    #2;
    chk("bp_count", int'(op_count), 11);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rand_step(70, 60);
    end
    drain();

    // Reset mid-operation: one presented, three queued.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i + 3), 4'(i), 3'd0, 1'b0);
    end
    #2;
    chk("mid_valid_before", int'(out_valid), 1);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_count", int'(op_count), 0);
    chk("mid_rst_all", int'({alu_a, alu_b, alu_op, out_y, out_carry, out_illegal}), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      idle_step(1'b1);
    end
    #2;
    chk("mid_no_result", int'(out_valid), 0);

    // Wrap: 256 accepted results bring op_count back to zero.
    guard = 0;
    while (total_acc < 256 && guard < 3000) begin
      rand_step(85, 90);
      guard++;
    end
    #2;
    chk("wrap_reached", (total_acc == 256) ? 1 : 0, 1);
    chk("wrap_count", int'(op_count), 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset; clock and reset listed first.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream request valid.
REQ-005 in_ready  output  1  request accepted this cycle if in_valid high.
REQ-006 in_a, in_b  input  4 each  operands.
REQ-007 in_op  input  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 illegal).
REQ-008 alu_a, alu_b  output  4 each  registered operands driven to the 4-bit combinational ALU.
REQ-009 alu_op  output  3  registered opcode driven to the ALU.
REQ-010 alu_y  input  4  ALU result.
REQ-011 alu_carry  input  1  ALU carry.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_y  output  4  captured result.
REQ-015 out_carry  output  1  captured carry.
REQ-016 out_illegal  output  1  captured result came from opcode 111.
REQ-017 op_count  output  8  count of results accepted downstream.

Function
REQ-018 SHALL buffer requests in a 4-entry FIFO of {a,b,op}; push when in_valid && in_ready.
REQ-019 in_ready SHALL equal (fifo count != 4), from registered count only; no push when full, even if a pop occurs in the same cycle.
REQ-020 FSM states SHALL be IDLE, ISSUE, RESULT.
REQ-021 IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_op at the edge and go ISSUE; else stay.
REQ-022 ISSUE: at the next edge capture alu_y, alu_carry, (alu_op==111) into out_y, out_carry, out_illegal, set out_valid, go RESULT.
REQ-023 RESULT: hold out_* and out_valid stable while out_ready low.
REQ-024 RESULT with out_ready high: clear out_valid, increment op_count; if FIFO non-empty pop next head into alu regs and go ISSUE, else go IDLE.
REQ-025 Latency: request pushed at edge N into an empty, IDLE block SHALL give out_valid high after edge N+2; sustained throughput one result per 2 cycles.
REQ-026 Push into an empty FIFO and IDLE pop SHALL NOT occur in the same edge (pop sees registered count).
REQ-027 Simultaneous push and pop with FIFO not full SHALL leave count unchanged and preserve order.
REQ-028 FIFO pointers SHALL wrap modulo 4; op_count SHALL wrap 255 -> 0.
REQ-029 alu_* SHALL hold their last value outside pops.
REQ-030 Opcode 111 SHALL be issued normally; out_illegal flags it, no other effect.

Reset
REQ-031 On rst_n low: FSM IDLE, FIFO empty, out_valid=0, out_y=0, out_carry=0, out_illegal=0, alu_a=alu_b=0, alu_op=000, op_count=0, immediately and asynchronously.
REQ-032 in_ready SHALL read 1 while in reset; in_valid SHALL be ignored until first edge after rst_n rises.
REQ-033 Reset mid-operation SHALL discard all buffered and in-flight requests; no result emitted for them.

Verification
REQ-034 Single add: push a=9,b=8,op=000, out_ready=1 -> out_valid high 2 edges later, out_y=1, out_carry=1, op_count=1.
REQ-035 Backpressure: out_ready=0, push 5 requests back-to-back -> in_ready low after 5th push accepted (4 buffered + 1 issued); then out_ready=1 -> 5 results in push order, op_count=5.
REQ-036 Illegal: push a=3,b=3,op=111 -> out_y=0, out_carry=0, out_illegal=1; next op 010 a=6,b=3 -> out_y=2, out_illegal=0.
REQ-037 Sub/shift: a=2,b=5,op=001 -> out_y=13, carry=0; a=9,op=101 -> out_y=2; a=9,op=110 -> out_y=4.
REQ-038 Reset mid-operation: 3 requests queued, out_valid high, assert rst_n low -> all outputs at reset values at once; after release no results until new push.
REQ-039 Wrap: complete 256 results -> op_count returns to 0; FIFO order correct across pointer wrap.
